// File: rtl/mymul_seq_shiftadd_pkg.sv
// Shared types for the sequential shift-add MYMUL implementation.
// This package holds the FSM state encoding and a constant-friendly ceil(log2) helper.
package mymul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns ceil(log2(n)), with a floor of 1, so that it can size indexes into n-bit vectors.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mymul_seq_shiftadd_if.sv
// Operand/result handshake bundle for mymul_seq_shiftadd.
// On each side a transfer happens on a rising edge where valid && ready; the source
// holds its data until that edge, and ready never depends on valid.
interface mymul_seq_shiftadd_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y
    );
endinterface

// File: rtl/mymul_seq_shiftadd_pow2_detect.sv
// Combinational one-hot detector: flags a multiplier that has exactly one set bit and
// reports the position of that bit, so that the top level can replace the product with a shift.
module mymul_pow2_detect
    import mymul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] b_i,
    output logic             is_pow2_o,
    output logic [IW-1:0]    idx_o
);
    logic [WIDTH-1:0] b_minus_one;

    always_comb begin
        b_minus_one = b_i - WIDTH'(1);
        is_pow2_o   = (b_i != '0) && ((b_i & b_minus_one) == '0);
        idx_o       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mymul_seq_shiftadd.sv
// Multi-cycle shift-add multiplier, Y = A*B mod 2^WIDTH, with valid/ready on both sides.
// It iterates one multiplier bit per cycle. There is an optional single-cycle path for a one-hot B.
module mymul_seq_shiftadd
    import mymul_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit POW2_FAST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mymul_seq_shiftadd_if.slave  bus,
    output state_e               state_o
);
    localparam int IW = clog2(WIDTH);
    localparam int CW = clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mcand_d;
    logic [WIDTH-1:0] mplier_d;
    logic [WIDTH-1:0] fast_y_d;
    logic             run_last;
    logic             is_pow2;
    logic [IW-1:0]    pow2_idx;

    generate
        if (POW2_FAST) begin : g_fast
            mymul_pow2_detect #(
                .WIDTH (WIDTH),
                .IW    (IW)
            ) u_pow2_detect (
                .b_i       (bus.b),
                .is_pow2_o (is_pow2),
                .idx_o     (pow2_idx)
            );
        end else begin : g_no_fast
            assign is_pow2  = 1'b0;
            assign pow2_idx = '0;
        end
    endgenerate

    // Each RUN cycle consumes the multiplier LSB. The loop ends once no set bits remain,
    // or when the last bit position has been used.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        run_last = (mplier_d == '0) || (cnt_q == CW'(WIDTH - 1));
        fast_y_d = bus.a << pow2_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q  <= bus.a;
                        mplier_q <= bus.b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        if (bus.b == '0) begin
                            y_q         <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (is_pow2) begin
                            y_q         <= fast_y_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (run_last) begin
                        y_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst so that the reset cycle cannot look like an accept to the source.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mymul_seq_shiftadd.sv
// Bench for mymul_seq_shiftadd. A fast-path instance and an always-iterate instance
// share one operand stream, and both are checked against an arithmetic reference.
module tb_mymul_seq_shiftadd;
    import mymul_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         drv_in_valid;
    logic [W-1:0] drv_a;
    logic [W-1:0] drv_b;
    logic         drv_out_ready;
    state_e       st_fast;
    state_e       st_slow;

    int checks;
    int errors;

    mymul_seq_shiftadd_if #(.WIDTH(W)) if_fast ();
    mymul_seq_shiftadd_if #(.WIDTH(W)) if_slow ();

    assign if_fast.in_valid  = drv_in_valid;
    assign if_fast.a         = drv_a;
    assign if_fast.b         = drv_b;
    assign if_fast.out_ready = drv_out_ready;
    assign if_slow.in_valid  = drv_in_valid;
    assign if_slow.a         = drv_a;
    assign if_slow.b         = drv_b;
    assign if_slow.out_ready = drv_out_ready;

    mymul_seq_shiftadd #(.WIDTH(W), .POW2_FAST(1'b1)) u_fast (
        .clk     (clk),
        .rst     (rst),
        .bus     (if_fast),
        .state_o (st_fast)
    );

    mymul_seq_shiftadd #(.WIDTH(W), .POW2_FAST(1'b0)) u_slow (
        .clk     (clk),
        .rst     (rst),
        .bus     (if_slow),
        .state_o (st_slow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the plain product and the documented latency rules.
    function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input bit fast);
        int msb;
        if (b == 0) return 1;
        if (fast && $countones(b) == 1) return 1;
        msb = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) msb = i;
        end
        return 2 + msb;
    endfunction

    // Driver: called at a negedge with both instances idle. It returns at a negedge
    // with both instances idle again.
    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input string tag);
        int       lat_exp [2];
        bit       seen [2];
        bit       post [2];
        logic     ov [2];
        logic     ir [2];
        logic [W-1:0] yv [2];
        logic [W-1:0] y_exp;
        int       c;
        lat_exp[0] = ref_lat(b_v, 1'b1);
        lat_exp[1] = ref_lat(b_v, 1'b0);
        y_exp      = ref_y(a_v, b_v);
        seen = '{0, 0};
        post = '{0, 0};
        drv_a = a_v;
        drv_b = b_v;
        drv_in_valid = 1'b1;
        drv_out_ready = 1'b1;
        check({tag, "_acc_rdy_f"}, 32'(if_fast.in_ready), 32'd1);
        check({tag, "_acc_rdy_s"}, 32'(if_slow.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drv_in_valid = 1'b0;
        drv_a = W'($urandom);
        drv_b = W'($urandom);
        c = 1;
        while (!(post[0] && post[1]) && c <= 2 * W + 4) begin
            ov[0] = if_fast.out_valid; ir[0] = if_fast.in_ready; yv[0] = if_fast.y;
            ov[1] = if_slow.out_valid; ir[1] = if_slow.in_ready; yv[1] = if_slow.y;
            for (int k = 0; k < 2; k++) begin
                if (!seen[k]) begin
                    if (ov[k]) begin
                        seen[k] = 1'b1;
                        check($sformatf("%s_lat%0d", tag, k), 32'(c), 32'(lat_exp[k]));
                        check($sformatf("%s_y%0d", tag, k), 32'(yv[k]), 32'(y_exp));
                    end else begin
                        check($sformatf("%s_busy_rdy%0d", tag, k), 32'(ir[k]), 32'd0);
                    end
                end else if (!post[k]) begin
                    post[k] = 1'b1;
                    check($sformatf("%s_post_ov%0d", tag, k), 32'(ov[k]), 32'd0);
                    check($sformatf("%s_post_rdy%0d", tag, k), 32'(ir[k]), 32'd1);
                end
            end
            if (!(post[0] && post[1])) begin
                @(negedge clk);
                c++;
            end
        end
        check({tag, "_timeout"}, {30'd0, post[1], post[0]}, 32'd3);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] held_y;
        int           c;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drv_in_valid = 1'b0;
        drv_a = '0;
        drv_b = '0;
        drv_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_ov_f", 32'(if_fast.out_valid), 32'd0);
        check("rst_y_f", 32'(if_fast.y), 32'd0);
        check("rst_rdy_f", 32'(if_fast.in_ready), 32'd0);
        check("rst_st_f", 32'(st_fast), 32'(IDLE));
        check("rst_ov_s", 32'(if_slow.out_valid), 32'd0);
        check("rst_rdy_s", 32'(if_slow.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_rdy_f", 32'(if_fast.in_ready), 32'd1);
        check("rel_rdy_s", 32'(if_slow.in_ready), 32'd1);
        @(negedge clk);

        // directed cases
        run_op(8'd13, 8'd11, "c1");
        run_op(8'h55, 8'h08, "c2");
        run_op(8'd200, 8'h00, "c3a");
        run_op(8'h00, 8'hFF, "c3b");
        run_op(8'hFF, 8'hFF, "c4");
        run_op(8'hFF, 8'h80, "msb_pow2");
        run_op(8'hA7, 8'h01, "b_one");

        // backpressure: the result is held for three cycles, then another op follows back-to-back
        drv_a = 8'd13;
        drv_b = 8'd11;
        drv_in_valid = 1'b1;
        drv_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drv_in_valid = 1'b0;
        c = 1;
        while (!(if_fast.out_valid && if_slow.out_valid) && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("bp_lat", 32'(c), 32'd5);
        held_y = ref_y(8'd13, 8'd11);
        for (int i = 0; i < 3; i++) begin
            check("bp_ov_f", 32'(if_fast.out_valid), 32'd1);
            check("bp_y_f", 32'(if_fast.y), 32'(held_y));
            check("bp_rdy_f", 32'(if_fast.in_ready), 32'd0);
            check("bp_ov_s", 32'(if_slow.out_valid), 32'd1);
            check("bp_y_s", 32'(if_slow.y), 32'(held_y));
            check("bp_rdy_s", 32'(if_slow.in_ready), 32'd0);
            @(negedge clk);
        end
        drv_out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ov_f", 32'(if_fast.out_valid), 32'd0);
        check("bp_rel_rdy_f", 32'(if_fast.in_ready), 32'd1);
        check("bp_rel_rdy_s", 32'(if_slow.in_ready), 32'd1);
        run_op(8'd77, 8'd93, "bp_next");

        // reset in the middle of RUN for case 4
        drv_a = 8'hFF;
        drv_b = 8'hFF;
        drv_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_rdy_in_rst", 32'(if_fast.in_ready), 32'd0);
        check("mr_st_run", 32'(st_fast), 32'(RUN));
        @(negedge clk);
        check("mr_ov", 32'(if_fast.out_valid), 32'd0);
        check("mr_y", 32'(if_fast.y), 32'd0);
        check("mr_st", 32'(st_fast), 32'(IDLE));
        rst = 1'b0;
        #1;
        check("mr_rdy_after", 32'(if_fast.in_ready), 32'd1);
        check("mr_rdy_after_s", 32'(if_slow.in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mr_no_stale", {30'd0, if_slow.out_valid, if_fast.out_valid}, 32'd0);
        end
        run_op(8'd3, 8'd5, "mr_new");

        // randomized operands, biased toward powers of two and the zero/all-ones extremes
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = W'(1) << $urandom_range(0, W - 1);
                1: rb = ($urandom_range(0, 1) == 0) ? W'(0) : {W{1'b1}};
                default: rb = W'($urandom);
            endcase
            run_op(ra, rb, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
